// File: rtl/dbus_bridge.sv
// dbus_bridge: single-master to NUM_SLV-slave data-bus bridge.
// Address decode selects one slave by base/mask (lowest index wins on overlap).
// The request is latched and held on the slave side until the selected slave acks
// or the wait counter expires. The result goes back to the master as a one-cycle m_ready pulse.
// Optional feature: define DBUS_ERR_CNT_EN to build a saturating 16-bit error counter
// on err_cnt. Without that macro, err_cnt is tied to zero.
module dbus_bridge #(
  parameter int                    NUM_SLV  = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE = {32'h8000_2000, 32'h8000_1000,
                                               32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*32-1:0] SLV_MSK  = {{3{32'hFFFF_F000}}, 32'hFFFC_0000},
  parameter int                    TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req,
  input  logic                  m_wen,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  input  logic [2:0]            m_mask,
  output logic                  m_ready,
  output logic [31:0]           m_rdata,
  output logic                  m_err,
  output logic [NUM_SLV-1:0]    s_sel,
  output logic                  s_wen,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  output logic [2:0]            s_mask,
  input  logic [NUM_SLV-1:0]    s_ack,
  input  logic [NUM_SLV*32-1:0] s_rdata,
  output logic [15:0]           err_cnt
);

  localparam int         IDX_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] idx_q, idx_nx;
  logic             wen_q, wen_nx;
  logic [31:0]      addr_q, addr_nx;
  logic [31:0]      wdata_q, wdata_nx;
  logic [2:0]       mask_q, mask_nx;
  logic [7:0]       wait_q, wait_nx;
  logic [31:0]      rdata_q, rdata_nx;
  logic             err_q, err_nx;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [NUM_SLV-1:0] sel_oh;
  logic [31:0]        sel_rdata;
  logic               sel_ack;

  // Address decode on the live master address; first matching slot wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (!hit && ((m_addr & SLV_MSK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // One-hot select and read-data mux for the latched slave index.
  always_comb begin
    sel_oh    = '0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_oh[i] = 1'b1;
        sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  // Acks from slaves other than the selected one are masked off here.
  assign sel_ack = |(s_ack & sel_oh);

  // Next-state logic and next values for the latched request and response.
  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    wen_nx   = wen_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    mask_nx  = mask_q;
    wait_nx  = wait_q;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (m_req) begin
          if (hit) begin
            idx_nx   = hit_idx;
            wen_nx   = m_wen;
            addr_nx  = m_addr;
            wdata_nx = m_wdata;
            mask_nx  = m_mask;
            wait_nx  = '0;
            state_nx = ACCESS;
          end else begin
            rdata_nx = '0;
            err_nx   = 1'b1;
            state_nx = RESP;
          end
        end
      end
      ACCESS: begin
        // An ack in the final wait cycle still completes the access successfully.
        if (sel_ack) begin
          rdata_nx = wen_q ? 32'h0 : sel_rdata;
          err_nx   = 1'b0;
          state_nx = RESP;
        end else if (wait_q == WAIT_LAST) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          wait_nx = wait_q + 8'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Latched request, wait counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_nx;
      wen_q   <= wen_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      mask_q  <= mask_nx;
      wait_q  <= wait_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
    end
  end

  assign m_ready = (state == RESP);
  assign m_err   = m_ready & err_q;
  assign m_rdata = m_ready ? rdata_q : 32'h0;
  assign s_sel   = (state == ACCESS) ? sel_oh : '0;
  assign s_wen   = wen_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_mask  = mask_q;

`ifdef DBUS_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Count error responses and hold the count at all-ones once it saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (m_ready && err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
